// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit multiplexed 7-segment scan with frame-synchronous loading.
// Optional macro SEG_HEX_EN decodes nibbles 10-15 as A-F instead of blank.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 65536,
   parameter int BLANK_CYCLES = 2,
   parameter int BLINK_DIV    = 8388608,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4*NUM_DIGITS-1:0]       digits_in,
   input  logic                          load,
   input  logic [NUM_DIGITS-1:0]         blank_mask,
   input  logic [NUM_DIGITS-1:0]         blink_mask,
   input  logic                          lz_suppress,
   input  logic                          all_on,
   output logic [NUM_DIGITS-1:0]         anode,
   output logic [6:0]                    seg,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_done
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] GAP = SW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [SW-1:0]           scan_cnt;
   logic [IW-1:0]           cur_idx;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_phase;
   logic                    pend_v;
   logic [4*NUM_DIGITS-1:0] pending;
   logic [4*NUM_DIGITS-1:0] shadow;

   logic                  slot_end;
   logic                  boundary;
   logic [3:0]            nib;
   logic [NUM_DIGITS-1:0] lz_dark;
   logic                  zero_run;
   logic                  dark;
   logic [NUM_DIGITS-1:0] anode_nx;
   logic [6:0]            seg_nx;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0: s = 7'h3F;
         4'd1: s = 7'h06;
         4'd2: s = 7'h5B;
         4'd3: s = 7'h4F;
         4'd4: s = 7'h66;
         4'd5: s = 7'h6D;
         4'd6: s = 7'h7D;
         4'd7: s = 7'h07;
         4'd8: s = 7'h7F;
         4'd9: s = 7'h6F;
`ifdef SEG_HEX_EN
         4'd10: s = 7'h77;
         4'd11: s = 7'h7C;
         4'd12: s = 7'h39;
         4'd13: s = 7'h5E;
         4'd14: s = 7'h79;
         default: s = 7'h71;
`else
         default: s = 7'h00;
`endif
      endcase
      return s;
   endfunction

   assign slot_end = (scan_cnt == SCAN_LAST);
   assign boundary = slot_end && (cur_idx == IDX_LAST);

   always_comb begin
      nib = 4'd0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (cur_idx == IW'(k)) nib = shadow[4*k +: 4];
      end
   end

   // A digit is suppressed only if it and every digit above it are zero.
   always_comb begin
      lz_dark  = '0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run   = zero_run && (shadow[4*k +: 4] == 4'd0);
         lz_dark[k] = zero_run;
      end
   end

   assign dark = blank_mask[cur_idx]
               | (blink_mask[cur_idx] & blink_phase)
               | (lz_suppress & lz_dark[cur_idx]);

   always_comb begin
      anode_nx = '0;
      seg_nx   = 7'h00;
      if (scan_cnt >= GAP) begin
         anode_nx[cur_idx] = 1'b1;
         if (all_on) seg_nx = 7'h7F;
         else if (!dark) seg_nx = decode(nib);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt    <= '0;
         cur_idx     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         pend_v      <= 1'b0;
         pending     <= '0;
         shadow      <= '0;
         frame_done  <= 1'b0;
         digit_idx   <= '0;
         anode       <= {NUM_DIGITS{POL}};
         seg         <= {7{POL}};
      end else begin
         scan_cnt <= slot_end ? '0 : scan_cnt + SW'(1);
         if (slot_end) begin
            cur_idx <= (cur_idx == IDX_LAST) ? '0 : cur_idx + IW'(1);
         end
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
         frame_done <= boundary;
         // A load on the boundary edge stays pending for the next frame.
         if (load) begin
            pending <= digits_in;
            pend_v  <= 1'b1;
         end else if (boundary && pend_v) begin
            pend_v <= 1'b0;
         end
         if (boundary && pend_v) shadow <= pending;
         digit_idx <= cur_idx;
         anode     <= anode_nx ^ {NUM_DIGITS{POL}};
         seg       <= seg_nx ^ {7{POL}};
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 4-cycle slots, 1-cycle gap, 32-cycle blink).
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits_in;
   logic        load;
   logic [3:0]  blank_mask;
   logic [3:0]  blink_mask;
   logic        lz_suppress;
   logic        all_on;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   seg_scan_driver #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
      .BLINK_DIV(32), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
      .blank_mask(blank_mask), .blink_mask(blink_mask),
      .lz_suppress(lz_suppress), .all_on(all_on), .anode(anode),
      .seg(seg), .digit_idx(digit_idx), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_until(input int n);
      while (cyc < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] ea,
                          input logic [6:0] es);
      chk({tag, "_anode"}, 32'(anode), 32'(ea));
      chk({tag, "_seg"}, 32'(seg), 32'(es));
   endtask

   initial begin
      reset = 1'b1; digits_in = '0; load = 1'b0; blank_mask = '0;
      blink_mask = '0; lz_suppress = 1'b0; all_on = 1'b0;
      tick(); tick();
      chk_out("rst", 4'hF, 7'h7F);
      chk("rst_idx", 32'(digit_idx), 0);
      chk("rst_fd", 32'(frame_done), 0);
      reset = 1'b0;
      cyc = 0;

      tick();
      chk_out("gap0", 4'hF, 7'h7F);
      tick();
      chk_out("d0_zero", 4'hE, 7'h40);
      chk("d0_idx", 32'(digit_idx), 0);
      run_until(16);
      chk("fd16", 32'(frame_done), 1);
      chk_out("d3_end", 4'h7, 7'h40);
      tick();
      chk("fd17", 32'(frame_done), 0);
      run_until(32);
      chk("fd32", 32'(frame_done), 1);

      run_until(36);
      load = 1'b1; digits_in = 16'h1234;
      tick();
      load = 1'b0;
      run_until(38);
      chk_out("preload_d1", 4'hD, 7'h40);
      run_until(46);
      chk_out("preload_d3", 4'h7, 7'h40);
      run_until(50);
      chk_out("l1234_d0", 4'hE, 7'h19);
      run_until(54);
      chk_out("l1234_d1", 4'hD, 7'h30);
      chk("l1234_idx1", 32'(digit_idx), 1);
      run_until(58);
      chk_out("l1234_d2", 4'hB, 7'h24);
      run_until(62);
      chk_out("l1234_d3", 4'h7, 7'h79);
      chk("l1234_idx3", 32'(digit_idx), 3);

      run_until(69);
      load = 1'b1; digits_in = 16'h1111;
      tick();
      load = 1'b0;
      run_until(74);
      chk_out("notear_d2", 4'hB, 7'h24);
      run_until(79);
      load = 1'b1; digits_in = 16'h5959;
      tick();
      load = 1'b0;
      run_until(82);
      chk_out("l1111_d0", 4'hE, 7'h79);
      run_until(94);
      chk_out("l1111_d3", 4'h7, 7'h79);
      run_until(98);
      chk_out("l5959_d0", 4'hE, 7'h10);
      run_until(102);
      chk_out("l5959_d1", 4'hD, 7'h12);

      run_until(99 + 4);
      run_until(99);
      load = 1'b1; digits_in = 16'h0050; lz_suppress = 1'b1;
      tick();
      load = 1'b0;
      run_until(114);
      chk_out("lz50_d0", 4'hE, 7'h40);
      run_until(118);
      chk_out("lz50_d1", 4'hD, 7'h12);
      run_until(122);
      chk_out("lz50_d2", 4'hB, 7'h7F);
      run_until(126);
      chk_out("lz50_d3", 4'h7, 7'h7F);
      run_until(129);
      load = 1'b1; digits_in = 16'h0000;
      tick();
      load = 1'b0;
      run_until(146);
      chk_out("lz00_d0", 4'hE, 7'h40);
      run_until(150);
      chk_out("lz00_d1", 4'hD, 7'h7F);

      run_until(159);
      blink_mask = 4'b0001;
      run_until(162);
      chk_out("blink_dark0", 4'hE, 7'h7F);
      run_until(178);
      chk_out("blink_dark1", 4'hE, 7'h7F);
      run_until(194);
      chk_out("blink_vis0", 4'hE, 7'h40);
      run_until(210);
      chk_out("blink_vis1", 4'hE, 7'h40);
      run_until(226);
      chk_out("blink_dark2", 4'hE, 7'h7F);

      run_until(227);
      blank_mask = 4'b0001; all_on = 1'b1;
      run_until(241);
      chk_out("allon_gap", 4'hF, 7'h7F);
      tick();
      chk_out("allon_d0", 4'hE, 7'h00);
      run_until(246);
      chk_out("allon_d1", 4'hD, 7'h00);
      all_on = 1'b0;
      run_until(258);
      chk_out("blank_d0", 4'hE, 7'h7F);

      run_until(259);
      lz_suppress = 1'b0; blank_mask = '0; blink_mask = '0;
      load = 1'b1; digits_in = 16'h000A;
      tick();
      load = 1'b0;
      run_until(274);
`ifdef SEG_HEX_EN
      chk_out("hexA_d0", 4'hE, 7'h08);
`else
      chk_out("hexA_d0", 4'hE, 7'h7F);
`endif
      run_until(278);
      chk_out("nolz_d1", 4'hD, 7'h40);

      run_until(279);
      reset = 1'b1;
      tick();
      chk_out("midrst", 4'hF, 7'h7F);
      chk("midrst_idx", 32'(digit_idx), 0);
      chk("midrst_fd", 32'(frame_done), 0);
      reset = 1'b0;
      cyc = 0;
      tick();
      chk_out("post_gap", 4'hF, 7'h7F);
      tick();
      chk_out("post_d0", 4'hE, 7'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed 7-segment scan driver. It generalises the fixed 4-digit anode/segment scan in the top-level to N digits, with these additions: tear-free frame-synchronous digit loading, per-digit blanking and blinking, leading-zero suppression, an all-segments alarm flash, and an inter-digit ghost-blanking gap. It sits between the time/alarm/stopwatch muxing logic and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; minimum 2.
- SCAN_DIV, 65536: clk cycles per digit slot; minimum 4.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; must be less than SCAN_DIV.
- BLINK_DIV, 8388608: clk cycles per blink half-period.
- ACTIVE_LOW, 1: 1 means anode and seg are active-low (board default); 0 means active-high.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- digits_in, input, 4*NUM_DIGITS: BCD nibbles; nibble 0 (bits 3:0) is the rightmost digit.
- load, input, 1: capture digits_in into the pending register.
- blank_mask, input, NUM_DIGITS: 1 forces the digit dark.
- blink_mask, input, NUM_DIGITS: 1 makes the digit blink.
- lz_suppress, input, 1: enable leading-zero suppression.
- all_on, input, 1: alarm flash; lights every segment.
- anode, output, NUM_DIGITS: digit enables; bit 0 is the rightmost digit.
- seg, output, 7: segments {g,f,e,d,c,b,a}, bit 0 = a.
- digit_idx, output, clog2(NUM_DIGITS): index of the digit currently being scanned.
- frame_done, output, 1: one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (sync, with priority over everything else):
  - scan_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=0, pend_v=0, pending=0, shadow=0, frame_done=0.
  - anode and seg all inactive: all 1s when ACTIVE_LOW=1, all 0s otherwise.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - At SCAN_DIV-1, digit_idx increments, wrapping NUM_DIGITS-1 to 0.
  - The wrap from NUM_DIGITS-1 to 0 is the frame boundary; frame_done is 1 for exactly that cycle.
- Loading:
  - load=1 sets pending<=digits_in and pend_v<=1; the latest load wins.
  - On a frame-boundary cycle with pend_v=1 (set before that cycle): shadow<=pending, pend_v<=0.
  - load coincident with a frame boundary: the older pending value goes to shadow; the new value is held pending (pend_v stays 1) and is applied at the next boundary.
  - Display never mixes two loads within a frame.
- Blink: blink_cnt counts 0..BLINK_DIV-1; at the terminal count blink_phase toggles. Free-running, independent of the scan.
- Leading-zero suppression (lz_suppress=1):
  - Digit k is dark when shadow nibble k and every nibble above it are 0.
  - Digit 0 is never suppressed; shadow=0 displays a single "0".
- Visibility of the current digit d (lowest to highest priority):
  1. Shown normally when none of the conditions below apply.
  2. Dark when blank_mask[d]=1.
  3. Dark when blink_mask[d]=1 and blink_phase=1.
  4. Dark when suppressed by leading-zero suppression.
  5. all_on=1 overrides all of the above: segments all lit on every digit.
- Dark digit: anode bit asserted, seg all inactive (keeps scan timing uniform).
- Ghost gap: while scan_cnt < BLANK_CYCLES, all anodes are inactive and seg is all inactive.
- Decode (active-high codes shown here; inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10-15 display blank.
- Latency: anode, seg and digit_idx are registered.
  - They reflect scan_cnt/digit_idx state from the previous cycle.
  - Mask, all_on and lz_suppress changes appear on outputs 1 cycle later.
  - New digit data appears at the first frame boundary after load, plus 1 cycle.

Optional Feature:
- Macro: SEG_HEX_EN.
- Defined: nibbles 10-15 decode to A=77, b=7C, C=39, d=5E, E=79, F=71 (active-high codes). Leading-zero suppression still treats only 0 as zero.
- Undefined: nibbles 10-15 display blank, as above.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_DIV=32, ACTIVE_LOW=1):
- Reset, then release -> anode=1111, seg=1111111. Digit 0 anode active (1110) from the 2nd cycle of its slot. frame_done pulses every 16 cycles.
- load with 0x1234 mid-frame -> no change until the boundary. Next frame shows seg ~06 on digit 3, ~5B on 2, ~4F on 1, ~66 on 0.
- load 0x1111, then load 0x5959 on the exact boundary cycle -> frame shows 1111; the following frame shows 5959.
- lz_suppress=1, shadow=0x0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. With shadow=0x0000, only digit 0 shows 0.
- blink_mask=0001 -> digit 0 seg dark for 32 cycles, visible for 32, repeating. all_on=1 -> seg=0000000 on all four digits, including a blanked digit 0.
- digits_in nibble=0xA -> blank without SEG_HEX_EN; seg=~77 with SEG_HEX_EN. Assert reset mid-slot -> all outputs return to reset values on the next edge.
